// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline constants for the hazard/stall controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_stall_unit_pkg;

  // Controller states: normal issue, multi-cycle hazard stall,
  // post-HALT drain of EX/MEM/WB, and terminal halted state.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // Cycles needed to let EX, MEM and WB retire after a HALT leaves decode.
  localparam int HALT_DRAIN_DEFAULT = 3;

  // Width of the shared stall/drain down-counter.
  localparam int CNT_W = 2;

endpackage

// File: rtl/hazard_match.sv
// Flags a decode source operand that depends on a given destination register.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
module hazard_match #(
  parameter int NB_REG = 5
) (
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [NB_REG-1:0] dest_rd,
  output logic              hit
);

  // Register 0 is hardwired to zero, so a write to it can never create a dependency.
  always_comb begin
    hit = (dest_rd != '0) &&
          ((id_use_rs && (id_rs == dest_rd)) ||
           (id_use_rt && (id_rt == dest_rd)));
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / decode-branch hazard stall and HALT drain controller.
// Latency: stall is asserted combinationally in the detecting cycle; HALT drains for HALT_DRAIN cycles.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; enable=0 freezes the whole unit.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int NB_REG     = 5,
  parameter int HALT_DRAIN = HALT_DRAIN_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_halt,
  input  logic [NB_REG-1:0] ex_rd,
  input  logic [NB_REG-1:0] mem_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              mem_mem_read,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              stall_active,
  output logic              halted
);

  // Counter value loaded on entering DRAIN; DRAIN lasts cnt+1 cycles.
  localparam logic [CNT_W-1:0] DRAIN_INIT =
    (HALT_DRAIN > 1) ? CNT_W'(HALT_DRAIN - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             halted_q;
  logic             ex_hit;
  logic             mem_hit;
  logic [1:0]       stall_len;

  hazard_match #(.NB_REG(NB_REG)) u_match_ex (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .dest_rd   (ex_rd),
    .hit       (ex_hit)
  );

  hazard_match #(.NB_REG(NB_REG)) u_match_mem (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .dest_rd   (mem_rd),
    .hit       (mem_hit)
  );

  // Stall length: branches resolve in decode, so they must also wait on ALU
  // results in EX and on loads still in MEM; a load in EX feeding a branch costs two.
  always_comb begin
    stall_len = 2'd0;
    if (id_branch && ex_mem_read && ex_hit) begin
      stall_len = 2'd2;
    end else if (id_branch && ((ex_reg_write && ex_hit) || (mem_mem_read && mem_hit))) begin
      stall_len = 2'd1;
    end else if (!id_branch && ex_mem_read && ex_hit) begin
      stall_len = 2'd1;
    end
  end

  // Pipeline control outputs; the first stall cycle is driven straight from RUN decode.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    id_ex_bubble = 1'b1;
    stall_active = 1'b0;
    if (reset) begin
      // hold everything while reset is applied
    end else if (!enable) begin
      id_ex_bubble = 1'b0;
      stall_active = (state == ST_STALL);
    end else begin
      case (state)
        ST_RUN: begin
          if (stall_len != 2'd0) begin
            stall_active = 1'b1;
          end else if (!id_halt) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
          end
        end
        ST_STALL: stall_active = 1'b1;
        default: begin
          // DRAIN and HALTED keep the front end frozen and bubbling
        end
      endcase
    end
  end

  // Halt is sticky until reset, but reads low during the reset cycle itself.
  always_comb begin
    halted = halted_q && !reset;
  end

  // State/counter sequencing; a single-cycle stall never leaves RUN, and
  // a HALT is only taken once no hazard is pending in decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RUN;
      cnt      <= '0;
      halted_q <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_RUN: begin
          if (stall_len == 2'd2) begin
            state <= ST_STALL;
            cnt   <= CNT_W'(1);
          end else if ((stall_len == 2'd0) && id_halt) begin
            state <= ST_DRAIN;
            cnt   <= DRAIN_INIT;
          end
        end
        ST_STALL: begin
          if (cnt <= CNT_W'(1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt == '0) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: table of single-cycle RUN vectors
// plus hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_hazard_stall_unit;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_use_rs, id_use_rt, id_branch, id_halt;
  logic       ex_reg_write, ex_mem_read, mem_mem_read;
  logic       pc_write, if_id_write, id_ex_bubble, stall_active, halted;

  hazard_stall_unit #(.NB_REG(5), .HALT_DRAIN(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_branch    (id_branch),
    .id_halt      (id_halt),
    .ex_rd        (ex_rd),
    .mem_rd       (mem_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .mem_mem_read (mem_mem_read),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_bubble (id_ex_bubble),
    .stall_active (stall_active),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       br;
    logic       ld_ex;
    logic       wr_ex;
    logic       ld_mem;
    logic [4:0] exrd;
    logic [4:0] memrd;
    logic [4:0] rs;
    logic       urs;
    logic [4:0] rt;
    logic       urt;
    logic       halt;
  } in_t;

  // {pc_write, if_id_write, id_ex_bubble, stall_active, halted}
  typedef logic [4:0] out_t;

  typedef struct {
    in_t   in;
    out_t  exp;
    string name;
  } vec_t;

  localparam out_t RUN_OK   = 5'b11000;
  localparam out_t STALL_O  = 5'b00110;
  localparam out_t HALTB    = 5'b00100;
  localparam out_t HALTED_O = 5'b00101;
  localparam out_t FROZEN   = 5'b00000;
  localparam out_t FROZ_STL = 5'b00010;
  localparam out_t FROZ_HLT = 5'b00001;
  localparam out_t RESET_O  = 5'b00100;

  int    tests_run = 0;
  int    tests_failed = 0;
  out_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[$];

  function automatic in_t mk(input logic br, input logic ld_ex, input logic wr_ex,
                             input logic ld_mem, input logic [4:0] exrd,
                             input logic [4:0] memrd, input logic [4:0] rs,
                             input logic urs, input logic [4:0] rt, input logic urt,
                             input logic halt);
    in_t v;
    v        = '0;
    v.en     = 1'b1;
    v.br     = br;
    v.ld_ex  = ld_ex;
    v.wr_ex  = wr_ex;
    v.ld_mem = ld_mem;
    v.exrd   = exrd;
    v.memrd  = memrd;
    v.rs     = rs;
    v.urs    = urs;
    v.rt     = rt;
    v.urt    = urt;
    v.halt   = halt;
    return v;
  endfunction

  function automatic in_t off(input in_t v);
    in_t r;
    r    = v;
    r.en = 1'b0;
    return r;
  endfunction

  function automatic in_t rst(input in_t v);
    in_t r;
    r     = v;
    r.rst = 1'b1;
    return r;
  endfunction

  task automatic drive(input in_t v);
    reset        = v.rst;
    enable       = v.en;
    id_branch    = v.br;
    ex_mem_read  = v.ld_ex;
    ex_reg_write = v.wr_ex;
    mem_mem_read = v.ld_mem;
    ex_rd        = v.exrd;
    mem_rd       = v.memrd;
    id_rs        = v.rs;
    id_use_rs    = v.urs;
    id_rt        = v.rt;
    id_use_rt    = v.urt;
    id_halt      = v.halt;
  endtask

  // One cycle: drive just after a rising edge, check at the falling edge,
  // then let the rising edge commit the state change.
  task automatic step(input in_t v, input out_t e, input string nm);
    out_t  got;
    out_t  want;
    string n;
    drive(v);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clock);
    got  = {pc_write, if_id_write, id_ex_bubble, stall_active, halted};
    want = exp_q.pop_front();
    n    = name_q.pop_front();
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got pc/ifid/bub/stall/halt=%b, expected %b", n, got, want);
    end
    @(posedge clock);
    #1;
  endtask

  in_t idle;
  in_t br_ld;
  in_t nb_ld;
  in_t hlt;

  initial begin
    idle  = mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    br_ld = mk(1, 1, 0, 0, 5'd8, 5'd0, 5'd8, 1, 5'd0, 0, 0);
    nb_ld = mk(0, 1, 0, 0, 5'd8, 5'd0, 5'd8, 1, 5'd0, 0, 0);
    hlt   = mk(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, 1);

    // Single-cycle vectors that all leave the unit in RUN.
    tbl.push_back('{idle,                                          RUN_OK,  "idle_run"});
    tbl.push_back('{nb_ld,                                         STALL_O, "load_use_rs"});
    tbl.push_back('{idle,                                          RUN_OK,  "after_load_use"});
    tbl.push_back('{mk(0, 1, 0, 0, 5'd9, 5'd0, 5'd1, 1, 5'd9, 1, 0), STALL_O, "load_use_rt"});
    tbl.push_back('{mk(0, 1, 0, 0, 5'd8, 5'd0, 5'd8, 0, 5'd0, 0, 0), RUN_OK,  "load_rs_unused"});
    tbl.push_back('{mk(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 1, 0), RUN_OK,  "load_r0"});
    tbl.push_back('{mk(0, 0, 1, 0, 5'd5, 5'd0, 5'd5, 1, 5'd0, 0, 0), RUN_OK,  "alu_fwd_no_stall"});
    tbl.push_back('{mk(1, 0, 1, 0, 5'd3, 5'd0, 5'd3, 1, 5'd0, 0, 0), STALL_O, "branch_ex_alu"});
    tbl.push_back('{mk(1, 0, 0, 1, 5'd0, 5'd4, 5'd1, 1, 5'd4, 1, 0), STALL_O, "branch_mem_load"});
    tbl.push_back('{mk(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 0, 0), RUN_OK,  "branch_r0_write"});
    tbl.push_back('{mk(1, 0, 0, 0, 5'd0, 5'd4, 5'd4, 1, 5'd0, 0, 0), RUN_OK,  "branch_mem_noload"});
    tbl.push_back('{mk(0, 0, 0, 1, 5'd0, 5'd4, 5'd4, 1, 5'd0, 0, 0), RUN_OK,  "nobranch_mem_load"});
    tbl.push_back('{mk(1, 1, 0, 0, 5'd7, 5'd0, 5'd6, 1, 5'd2, 1, 0), RUN_OK,  "branch_mismatch"});
    tbl.push_back('{mk(0, 1, 0, 0, 5'd8, 5'd0, 5'd8, 1, 5'd0, 0, 1), STALL_O, "hazard_over_halt"});
    tbl.push_back('{off(nb_ld),                                    FROZEN,  "frozen_run"});
    tbl.push_back('{idle,                                          RUN_OK,  "run_after_freeze"});

    reset = 1'b1;
    drive(rst(idle));
    @(posedge clock);
    #1;

    // Reset state, including reset winning over a cleared enable.
    step(rst(off(idle)), RESET_O, "reset_over_enable");
    step(rst(br_ld),     RESET_O, "reset_outputs");

    foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].name);

    // Branch fed by a load in EX: two stall cycles, inputs ignored in the second.
    step(br_ld, STALL_O, "br_load_cyc1");
    step(hlt,   STALL_O, "br_load_cyc2");
    step(idle,  RUN_OK,  "br_load_done");

    // Two-cycle stall with a 3-cycle freeze in the middle.
    step(br_ld,      STALL_O,  "pause_cyc1");
    step(off(idle),  FROZ_STL, "pause_f1");
    step(off(br_ld), FROZ_STL, "pause_f2");
    step(off(hlt),   FROZ_STL, "pause_f3");
    step(idle,       STALL_O,  "pause_cyc2");
    step(idle,       RUN_OK,   "pause_done");

    // Reset mid-stall.
    step(br_ld,     STALL_O, "rst_stall_cyc1");
    step(rst(idle), RESET_O, "rst_stall_reset");
    step(idle,      RUN_OK,  "rst_stall_run");

    // HALT: three drain cycles, then sticky halted until reset.
    step(hlt,       HALTB,    "halt_accept");
    step(idle,      HALTB,    "drain_1");
    step(idle,      HALTB,    "drain_2");
    step(idle,      HALTB,    "drain_3");
    step(idle,      HALTED_O, "halted_1");
    step(br_ld,     HALTED_O, "halted_sticky");
    step(off(idle), FROZ_HLT, "halted_frozen");
    step(idle,      HALTED_O, "halted_again");
    step(rst(idle), RESET_O,  "halted_reset");
    step(idle,      RUN_OK,   "halted_cleared");

    // Reset during DRAIN with one cycle left to count.
    step(hlt,       HALTB,   "rd_accept");
    step(idle,      HALTB,   "rd_drain_1");
    step(rst(idle), RESET_O, "rd_reset");
    step(idle,      RUN_OK,  "rd_run");

    // Freeze in the middle of DRAIN keeps the remaining count.
    step(hlt,       HALTB,    "dp_accept");
    step(idle,      HALTB,    "dp_drain_1");
    step(off(idle), FROZEN,   "dp_f1");
    step(off(idle), FROZEN,   "dp_f2");
    step(idle,      HALTB,    "dp_drain_2");
    step(idle,      HALTB,    "dp_drain_3");
    step(idle,      HALTED_O, "dp_halted");
    step(rst(idle), RESET_O,  "dp_reset");

    // HALT held through a two-cycle stall is only taken afterwards.
    step(mk(1, 1, 0, 0, 5'd8, 5'd0, 5'd8, 1, 5'd0, 0, 1), STALL_O, "hs_cyc1");
    step(hlt,  STALL_O, "hs_cyc2");
    step(hlt,  HALTB,   "hs_accept");
    step(idle, HALTB,   "hs_drain_1");

    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected done", $time);
    $fatal(1, "watchdog");
  end

endmodule
